// File: rtl/voice_mixer_if.sv
// Mixer-side bundle: strobe and per-voice snapshot inputs in, mixed sample and status out.
interface voice_mixer_if #(parameter int NUM_VOICES = 4);
  logic                      sample_strobe;
  logic [16*NUM_VOICES-1:0]  osc_in;
  logic [8*NUM_VOICES-1:0]   env_in;
  logic [NUM_VOICES-1:0]     voice_en;
  logic [7:0]                master_vol;
  logic [15:0]               mix_out;
  logic                      mix_valid;
  logic                      clip;
  logic                      busy;
  logic                      overrun;

  modport master (
    output sample_strobe, osc_in, env_in, voice_en, master_vol,
    input  mix_out, mix_valid, clip, busy, overrun
  );

  modport slave (
    input  sample_strobe, osc_in, env_in, voice_en, master_vol,
    output mix_out, mix_valid, clip, busy, overrun
  );
endinterface

// File: rtl/voice_mixer.sv
// Envelope-scaled voice mixer: snapshot on strobe, one multiply-accumulate per voice,
// master gain, then saturation to signed 16 bits.
//
// state | meaning
// IDLE  | waiting for sample_strobe
// SNAP  | snapshot held, accumulator cleared
// ACCUM | adding voice idx into the accumulator
// SCALE | applying master gain and saturating into mix_out
module voice_mixer #(
  parameter int NUM_VOICES = 4
) (
  input logic          clk,
  input logic          rst_n,
  voice_mixer_if.slave bus
);
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int AW = 17 + $clog2(NUM_VOICES);
  localparam int SW = AW + 2;

  typedef enum logic [1:0] {IDLE, SNAP, ACCUM, SCALE} state_t;

  state_t state, state_nxt;
  logic   snap_en, accum_en, scale_en, last_voice;

  logic signed [15:0]    osc_q [NUM_VOICES];
  logic [7:0]            env_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] en_q;
  logic [7:0]            vol_q;
  logic [IW-1:0]         idx;
  logic signed [AW-1:0]  acc;

  logic [15:0] mix_out_q;
  logic        mix_valid_q, clip_q, overrun_q;

  logic signed [24:0]   prod;
  logic signed [16:0]   term;
  logic [8:0]           gain;
  logic signed [AW+9:0] sprod;
  logic signed [SW-1:0] s;
  logic [SW-16:0]       s_hi;
  logic                 in_range;
  logic [15:0]          sat_val;

  assign last_voice = (idx == IW'(NUM_VOICES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    snap_en   = 1'b0;
    accum_en  = 1'b0;
    scale_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sample_strobe) begin
          snap_en   = 1'b1;
          state_nxt = SNAP;
        end
      end
      SNAP:  state_nxt = ACCUM;
      ACCUM: begin
        accum_en = 1'b1;
        if (last_voice) state_nxt = SCALE;
      end
      SCALE: begin
        scale_en  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Both shifts are plain arithmetic shifts, so results truncate toward -inf.
  always_comb begin
    prod     = osc_q[idx] * $signed({1'b0, env_q[idx]});
    term     = 17'(prod >>> 8);
    gain     = {1'b0, vol_q} + 9'd1;
    sprod    = acc * $signed({1'b0, gain});
    s        = SW'(sprod >>> 8);
    s_hi     = s[SW-1:15];
    in_range = (&s_hi) | ~(|s_hi);
    sat_val  = in_range ? s[15:0] : (s[SW-1] ? 16'h8000 : 16'h7fff);
  end

  // The snapshot is taken on the strobe edge itself, so anything the upstream
  // stages change during the SNAP cycle cannot leak into this mix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        osc_q[i] <= '0;
        env_q[i] <= '0;
      end
      en_q        <= '0;
      vol_q       <= '0;
      idx         <= '0;
      acc         <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q   <= bus.sample_strobe && (state != IDLE);
      mix_valid_q <= scale_en;
      if (snap_en) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          osc_q[i] <= $signed(bus.osc_in[16*i +: 16]);
          env_q[i] <= bus.env_in[8*i +: 8];
        end
        en_q  <= bus.voice_en;
        vol_q <= bus.master_vol;
        idx   <= '0;
        acc   <= '0;
      end
      if (accum_en) begin
        if (en_q[idx]) acc <= acc + AW'(term);
        idx <= idx + 1'b1;
      end
      if (scale_en) begin
        mix_out_q <= sat_val;
        clip_q    <= ~in_range;
      end
    end
  end

  assign bus.mix_out   = mix_out_q;
  assign bus.mix_valid = mix_valid_q;
  assign bus.clip      = clip_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: doc/voice_mixer.md
# voice_mixer

- Downstream of the per-voice oscillator and `wavegen_adsr` stages.
- On each 48 kHz `sample_strobe`, snapshots every voice's oscillator sample and 8-bit envelope.
- Scales each sample by its envelope, then sums the enabled voices sequentially with one multiply per clock.
- Applies the master volume and saturates to a signed 16-bit result with a one-cycle valid pulse, for the DAC/serialiser stage.

## Interface
- `NUM_VOICES`, default 4: number of voices. Must be a power of two, 2..8.
- `clk`  in  1: 49.152 MHz audio clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `sample_strobe`  in  1: one-cycle pulse per sample period; starts a mix.
- `osc_in`  in  16*NUM_VOICES: packed signed oscillator samples; voice i is `[16*i+15:16*i]`.
- `env_in`  in  8*NUM_VOICES: packed unsigned envelopes (0–255); voice i is `[8*i+7:8*i]`.
- `voice_en`  in  NUM_VOICES: per-voice enable. A disabled voice contributes 0.
- `master_vol`  in  8: master gain. Effective multiplier is (master_vol+1)/256, so 255 means unity.
- `mix_out`  out  16: signed mixed sample, held between updates.
- `mix_valid`  out  1: one-cycle pulse when `mix_out` updates.
- `clip`  out  1: set when the current `mix_out` was saturated; updates together with `mix_out`.
- `busy`  out  1: high while a mix is in progress (any state other than IDLE).
- `overrun`  out  1: one-cycle pulse when `sample_strobe` arrives while `busy`.

## Operation
- States and transitions:
  - IDLE → SNAP on `sample_strobe`.
  - SNAP → ACCUM.
  - ACCUM → SCALE after voice NUM_VOICES-1.
  - SCALE → IDLE.
- SNAP:
  - Registers all of `osc_in`, `env_in`, `voice_en` and `master_vol`.
  - Clears the accumulator and sets voice index to 0.
  - Later input changes do not affect the mix in progress.
- Envelope lag: `wavegen_adsr` updates on the same strobe, so the snapshot holds the pre-update envelope. This one-sample lag is intended.
- ACCUM, one voice per cycle:
  - prod = signed(osc_i) × {1'b0, env_i}, 25-bit signed.
  - term = prod >>> 8 (arithmetic shift, truncates toward −∞), 17-bit.
  - acc += voice_en_i ? term : 0.
  - acc width is 17+log2(NUM_VOICES) bits and never overflows internally.
- SCALE:
  - s = (acc × (master_vol+1)) >>> 8.
  - Saturate s to [−32768, 32767], register it into `mix_out` and set `clip` = (s was out of range).
  - Pulse `mix_valid`.
- Strobe while busy:
  - Ignored; the mix in progress completes unaffected.
  - `overrun` pulses in the cycle after that strobe.
  - A strobe coincident with the SCALE cycle is also ignored, with `overrun` pulsed.
- No rounding anywhere; both shifts truncate.
- Reset, asynchronous and valid at any time including mid-mix:
  - State → IDLE.
  - `mix_out` = 0, `mix_valid` = 0, `clip` = 0, `busy` = 0, `overrun` = 0.
  - Accumulator and snapshot registers cleared.
- After reset deassertion, the first `sample_strobe` starts a normal mix.

## Timing
- Strobe sampled high at edge E0 → SNAP during the following cycle.
- Edges E2..E(N+1) accumulate voices 0..N-1.
- Edge E(N+2) executes SCALE: `mix_out`, `clip` and `mix_valid` update.
- Latency: `mix_valid` is high in the cycle beginning at edge E(N+2), i.e. N+2 clocks after the strobe cycle. That is 6 clocks for N=4.
- `busy` is high from the cycle after E0 through the SCALE cycle, N+2 cycles total, and low in the `mix_valid` cycle.
- Throughput: one mix per N+3 clocks minimum. The 1024-clock sample period gives ample margin.
- `mix_out` and `clip` are stable from the `mix_valid` cycle until the next `mix_valid`.

## Test plan
- Latency and unity gain: N=4, voice0 osc=0x4000, env=255, en=0001, master=255 → `mix_out`=16320, `clip`=0, `mix_valid` exactly 6 clocks after the strobe, `busy` high for exactly the 6 strobe-to-SCALE cycles and low in the `mix_valid` cycle.
- Negative and truncation cases:
  - osc=−32768, env=128, one voice, master=255 → −16384.
  - osc=−1, env=1 → −1, showing truncation toward −∞.
  - osc=1, env=1 → 0.
- Saturation:
  - All 4 voices osc=32767, env=255, master=255 → acc=130556, `mix_out`=32767, `clip`=1.
  - All osc=−32768 → `mix_out`=−32768, `clip`=1.
  - Same positive case with master=63 → 32639, `clip`=0.
- Enable and snapshot: voices 1 and 3 enabled with osc=1000, env=255 each (others nonzero but disabled); change `osc_in` on the cycle after the strobe → `mix_out`=1992, unaffected by the change.
- Overrun:
  - Strobe again 2 cycles after the first → `overrun` pulses once and the result matches the single-strobe result.
  - Repeat with the second strobe in the SCALE cycle.
- Reset mid-mix: assert `rst_n` low asynchronously during ACCUM → all outputs 0 immediately, no `mix_valid`; the next strobe after release produces a correct mix.
